jtag_fb_cmd_ctrl: RTL and testbench

Command controller between the ECP5 JTAGG ER1 user chain and the RGB LED-matrix pixel framebuffer. It shifts a command word in on ER1 and decodes it on Update-DR. It then sequences single writes, auto-increment writes, reads and whole-frame fills on the framebuffer port, and returns status and read data at the next Capture-DR. The block runs entirely in the JTCK domain and sits between the JTAGG instance and the LED matrix driver.

---
 rtl/jtag_fb_cmd_ctrl.sv | 170 +++++++++++++++++
 tb/tb_jtag_fb_cmd_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_fb_cmd_ctrl.sv
// JTAG ER1 command controller for the LED-matrix framebuffer.
// Decodes a 40-bit command on Update-DR and sequences writes, reads and fills.
//
// state     | meaning
// ----------+--------------------------------------------------
// S_IDLE    | waiting for an ER1 update event
// S_WR      | single write strobe at cur_addr
// S_RD_REQ  | read strobe at cur_addr
// S_RD_WAIT | latch fb_rdata into rd_data, set rd_valid
// S_FILL    | write data to every address, one per cycle
module jtag_fb_cmd_ctrl #(
  parameter int NUM_PIXELS = 40,
  parameter int ADDR_W     = 6,
  parameter int DATA_W     = 30
) (
  input  logic              JTCK,
  input  logic              JRSTN,
  input  logic              JTDI,
  input  logic              JSHIFT,
  input  logic              JUPDATE,
  input  logic              JCE1,
  input  logic              JRTI1,
  output logic              JTDO1,
  output logic              fb_we,
  output logic              fb_re,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [DATA_W-1:0] fb_wdata,
  input  logic [DATA_W-1:0] fb_rdata,
  output logic              busy
);

  localparam int SR_W = 4 + ADDR_W + DATA_W;
  localparam logic [3:0] OP_WRITE     = 4'h1;
  localparam logic [3:0] OP_READ      = 4'h2;
  localparam logic [3:0] OP_WRITE_INC = 4'h3;
  localparam logic [3:0] OP_FILL      = 4'h4;
  localparam logic [3:0] OP_CLR       = 4'hF;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIXELS - 1);

  typedef enum logic [2:0] {S_IDLE, S_WR, S_RD_REQ, S_RD_WAIT, S_FILL} state_t;

  state_t state, state_nx;
  logic [SR_W-1:0]   sr;
  logic              sel1, upd_q, inc_q;
  logic              overrun, addr_err, rd_valid;
  logic [ADDR_W-1:0] cur_addr, cur_next;
  logic [DATA_W-1:0] wdata, rd_data;
  logic [3:0]        opcode;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_data;
  logic              upd_ev, addr_ok, capture, shift;
  logic              unused_rti;

  assign unused_rti = JRTI1;
  assign opcode     = sr[SR_W-1 -: 4];
  assign cmd_addr   = sr[DATA_W +: ADDR_W];
  assign cmd_data   = sr[DATA_W-1:0];
  assign capture    = JCE1 & ~JSHIFT;
  assign shift      = JCE1 & JSHIFT;
  // sel1 limits update events to scans that went through ER1 capture
  assign upd_ev     = JUPDATE & ~upd_q & sel1;
  assign addr_ok    = (cmd_addr <= LAST_ADDR);
  assign cur_next   = (cur_addr == LAST_ADDR) ? '0 : cur_addr + ADDR_W'(1);

  assign JTDO1    = sr[0];
  assign busy     = (state != S_IDLE);
  assign fb_addr  = cur_addr;
  assign fb_wdata = wdata;

  always_ff @(posedge JTCK) begin
    if (!JRSTN) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    fb_we    = 1'b0;
    fb_re    = 1'b0;
    case (state)
      S_IDLE: begin
        if (upd_ev) begin
          case (opcode)
            OP_WRITE, OP_WRITE_INC: if (addr_ok) state_nx = S_WR;
            OP_READ:                if (addr_ok) state_nx = S_RD_REQ;
            OP_FILL:                state_nx = S_FILL;
            default:                state_nx = S_IDLE;
          endcase
        end
      end
      S_WR: begin
        fb_we    = 1'b1;
        state_nx = S_IDLE;
      end
      S_RD_REQ: begin
        fb_re    = 1'b1;
        state_nx = S_RD_WAIT;
      end
      S_RD_WAIT: state_nx = S_IDLE;
      S_FILL: begin
        fb_we = 1'b1;
        if (cur_addr == LAST_ADDR) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge JTCK) begin
    if (!JRSTN) begin
      sr       <= '0;
      sel1     <= 1'b0;
      upd_q    <= 1'b0;
      inc_q    <= 1'b0;
      overrun  <= 1'b0;
      addr_err <= 1'b0;
      rd_valid <= 1'b0;
      cur_addr <= '0;
      wdata    <= '0;
      rd_data  <= '0;
    end else begin
      upd_q <= JUPDATE;
      if (capture)    sr <= {busy, overrun, addr_err, rd_valid, cur_addr, rd_data};
      else if (shift) sr <= {JTDI, sr[SR_W-1:1]};

      if (upd_ev)       sel1 <= 1'b0;
      else if (capture) sel1 <= 1'b1;

      if (upd_ev && busy) begin
        overrun <= 1'b1;
      end else if (upd_ev) begin
        case (opcode)
          OP_WRITE, OP_WRITE_INC: begin
            if (addr_ok) begin
              cur_addr <= cmd_addr;
              wdata    <= cmd_data;
              inc_q    <= (opcode == OP_WRITE_INC);
            end else begin
              addr_err <= 1'b1;
            end
          end
          OP_READ: begin
            rd_valid <= 1'b0;
            if (addr_ok) cur_addr <= cmd_addr;
            else         addr_err <= 1'b1;
          end
          OP_FILL: begin
            cur_addr <= '0;
            wdata    <= cmd_data;
          end
          OP_CLR: begin
            overrun  <= 1'b0;
            addr_err <= 1'b0;
            rd_valid <= 1'b0;
          end
          default: ;
        endcase
      end

      case (state)
        S_WR:      if (inc_q) cur_addr <= cur_next;
        S_RD_WAIT: begin
          rd_data  <= fb_rdata;
          rd_valid <= 1'b1;
        end
        S_FILL:    cur_addr <= cur_next;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_jtag_fb_cmd_ctrl.sv
// Bench for jtag_fb_cmd_ctrl: JTAG scan driver, time-based reference model,
// and a strobe scoreboard drained by an independent monitor.
module tb_jtag_fb_cmd_ctrl;
  localparam int NP = 40;

  logic JTCK = 0, JRSTN = 0, JTDI = 0, JSHIFT = 0, JUPDATE = 0, JCE1 = 0, JRTI1 = 0;
  logic JTDO1, fb_we, fb_re, busy;
  logic [5:0]  fb_addr;
  logic [29:0] fb_wdata;
  logic [29:0] fb_rdata;

  jtag_fb_cmd_ctrl dut (
    .JTCK(JTCK), .JRSTN(JRSTN), .JTDI(JTDI), .JSHIFT(JSHIFT), .JUPDATE(JUPDATE),
    .JCE1(JCE1), .JRTI1(JRTI1), .JTDO1(JTDO1), .fb_we(fb_we), .fb_re(fb_re),
    .fb_addr(fb_addr), .fb_wdata(fb_wdata), .fb_rdata(fb_rdata), .busy(busy)
  );

  always #5 JTCK = ~JTCK;

  int cyc = 0;
  always @(posedge JTCK) cyc <= cyc + 1;

  // framebuffer with a bench-side preload port
  logic [29:0] fb_mem [NP];
  logic        pl_en = 0;
  logic [5:0]  pl_addr = 0;
  logic [29:0] pl_data = 0;
  always @(posedge JTCK) begin
    if (pl_en) fb_mem[pl_addr] <= pl_data;
    else if (fb_we && fb_addr < NP) fb_mem[fb_addr] <= fb_wdata;
    if (fb_re && fb_addr < NP) fb_rdata <= fb_mem[fb_addr];
  end

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct { int cyc; bit rd; logic [5:0] addr; logic [29:0] data; } exp_t;
  exp_t q[$];

  always @(negedge JTCK) begin
    exp_t e;
    if (fb_we === 1'b1 || fb_re === 1'b1) begin
      if (q.size() == 0) chk("unexpected_strobe", {fb_we, fb_re, fb_addr}, 0);
      else begin
        e = q.pop_front();
        chk("strobe_kind", {fb_we, fb_re}, e.rd ? 2'b01 : 2'b10);
        chk("strobe_cycle", cyc, e.cyc);
        chk("strobe_addr", fb_addr, e.addr);
        if (!e.rd) chk("strobe_wdata", fb_wdata, e.data);
      end
    end else if (q.size() > 0 && q[0].cyc < cyc) begin
      e = q.pop_front();
      chk("missed_strobe_cycle", cyc, e.cyc);
    end
  end

  // reference model: committed state plus the most recent accepted operation
  logic [29:0] ref_mem [NP];
  bit          m_ov, m_ae, b_rv;
  logic [5:0]  b_cur;
  logic [29:0] b_rd;
  int          op_kind, op_u, op_addr, last_u;  // op_kind 0 none,1 wr,2 wr_inc,3 rd,4 fill
  logic [29:0] op_rdat;

  function automatic logic [5:0] nxt(input int a);
    return (a == NP - 1) ? 6'd0 : 6'(a + 1);
  endfunction

  function automatic int op_len();
    case (op_kind)
      1, 2: return 1;
      3: return 2;
      4: return NP;
      default: return 0;
    endcase
  endfunction

  function automatic bit busy_at(input int c);
    return op_kind != 0 && c > op_u && c <= op_u + op_len();
  endfunction

  function automatic logic [39:0] status_at(input int c);
    logic [5:0] cur = b_cur;
    bit rv = b_rv;
    logic [29:0] rd = b_rd;
    if (c > op_u) begin
      case (op_kind)
        1: cur = 6'(op_addr);
        2: cur = (c >= op_u + 2) ? nxt(op_addr) : 6'(op_addr);
        3: begin
          cur = 6'(op_addr);
          rv = (c >= op_u + 3);
          if (rv) rd = op_rdat;
        end
        4: cur = (c - op_u <= NP) ? 6'(c - op_u - 1) : 6'd0;
        default: ;
      endcase
    end
    return {busy_at(c), m_ov, m_ae, rv, cur, rd};
  endfunction

  task automatic model_reset();
    m_ov = 0; m_ae = 0; b_rv = 0; b_cur = 0; b_rd = 0; op_kind = 0; op_u = 0;
    q.delete();
  endtask

  task automatic model_update(input logic [39:0] cmd, input int u);
    logic [39:0] s;
    int a;
    logic [29:0] d;
    if (busy_at(u)) begin m_ov = 1; return; end
    s = status_at(1 << 30);
    b_cur = s[35:30]; b_rv = s[36]; b_rd = s[29:0]; op_kind = 0;
    a = int'(cmd[35:30]); d = cmd[29:0];
    case (cmd[39:36])
      4'h1, 4'h3: if (a < NP) begin
          op_kind = (cmd[39:36] == 4'h1) ? 1 : 2; op_u = u; op_addr = a;
          q.push_back('{u + 1, 1'b0, 6'(a), d});
          ref_mem[a] = d;
        end else m_ae = 1;
      4'h2: begin
        b_rv = 0;
        if (a < NP) begin
          op_kind = 3; op_u = u; op_addr = a; op_rdat = ref_mem[a];
          q.push_back('{u + 1, 1'b1, 6'(a), 30'd0});
        end else m_ae = 1;
      end
      4'h4: begin
        op_kind = 4; op_u = u;
        for (int k = 0; k < NP; k++) begin
          q.push_back('{u + 1 + k, 1'b0, 6'(k), d});
          ref_mem[k] = d;
        end
      end
      4'hF: begin m_ov = 0; m_ae = 0; b_rv = 0; end
      default: ;
    endcase
  endtask

  task automatic step();
    @(posedge JTCK);
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic preload(input int a, input logic [29:0] d);
    pl_en = 1; pl_addr = 6'(a); pl_data = d; ref_mem[a] = d;
    step();
    pl_en = 0;
  endtask

  task automatic scan(input logic [39:0] cmd, input bit upd, input string tag,
                      output logic [39:0] cap);
    int c;
    step(); JCE1 = 1; JSHIFT = 0; c = cyc;
    for (int i = 0; i < 40; i++) begin
      step(); JSHIFT = 1; JTDI = cmd[i]; cap[i] = JTDO1;
    end
    step(); JCE1 = 0; JSHIFT = 0; JTDI = 0;
    chk(tag, cap, status_at(c));
    if (upd) begin
      step(); JUPDATE = 1; last_u = cyc; model_update(cmd, cyc);
      step(); JUPDATE = 0;
    end
  endtask

  // capture followed directly by update, no shifting: sr holds the captured status
  task automatic quick_update();
    int c;
    step(); JCE1 = 1; JSHIFT = 0; c = cyc;
    step(); JCE1 = 0;
    step(); JUPDATE = 1; model_update(status_at(c), cyc);
    step(); JUPDATE = 0;
  endtask

  function automatic logic [39:0] mk(input logic [3:0] op, input logic [5:0] a, input logic [29:0] d);
    return {op, a, d};
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [39:0] cap;
    logic [29:0] saved [NP];
    logic [3:0] ops [8];
    logic [3:0] op;
    logic [29:0] d;
    ops[0] = 4'h0; ops[1] = 4'h1; ops[2] = 4'h2; ops[3] = 4'h3;
    ops[4] = 4'h4; ops[5] = 4'hF; ops[6] = 4'h5; ops[7] = 4'h1;
    model_reset();
    for (int i = 0; i < NP; i++) preload(i, 30'($urandom));
    chk("reset_busy", busy, 0);
    chk("reset_strobes", {fb_we, fb_re}, 0);
    chk("reset_addr_wdata", {fb_addr, fb_wdata}, 0);
    chk("reset_tdo", JTDO1, 0);
    JRSTN = 1;

    scan(40'd0, 0, "reset_capture", cap);
    chk("reset_capture_zero", cap, 0);

    scan(mk(4'h1, 6'd5, 30'h3FF00000), 1, "cap_before_write", cap);
    idle(3);
    step(); JUPDATE = 1;   // update with no ER1 capture must be ignored
    step(); JUPDATE = 0;
    idle(2);

    preload(12, 30'h0ABCDEF);
    scan(mk(4'h2, 6'd12, 30'd0), 1, "cap_before_read", cap);
    idle(3);
    scan(40'd0, 1, "cap_read_result", cap);
    chk("read_data", cap[29:0], 30'h0ABCDEF);
    chk("read_valid_cur", cap[36:30], {1'b1, 6'd12});

    scan(mk(4'h3, 6'd39, 30'h1234567), 1, "cap_inc1", cap);
    scan(mk(4'h3, 6'd0, 30'h2345678), 1, "cap_inc2", cap);
    scan(40'd0, 1, "cap_after_inc", cap);
    chk("inc_cur_addr", cap[35:30], 6'd1);

    scan(mk(4'h4, 6'd0, 30'h15555555), 1, "cap_before_fill", cap);
    idle(6);
    quick_update();
    idle(45);
    scan(mk(4'hF, 6'd0, 30'd0), 1, "cap_overrun", cap);
    chk("overrun_flag", cap[38], 1);
    scan(40'd0, 1, "cap_after_clr", cap);
    chk("clr_flags", cap[39:36], 0);

    scan(mk(4'h1, 6'd40, 30'h3FFFFFFF), 1, "cap_before_bad", cap);
    idle(3);
    scan(40'd0, 1, "cap_addr_err", cap);
    chk("addr_err_flag", cap[37], 1);

    for (int i = 0; i < NP; i++) saved[i] = ref_mem[i];
    scan(mk(4'h4, 6'd0, 30'h2AAAAAAA), 1, "cap_before_fill2", cap);
    while (cyc < last_u + 21) step();
    JRSTN = 0;
    chk("fill_at_20", {fb_we, fb_addr}, {1'b1, 6'd20});
    step();
    JRSTN = 1;
    model_reset();
    for (int i = 21; i < NP; i++) ref_mem[i] = saved[i];
    chk("abort_strobe_busy", {fb_we, fb_re, busy}, 0);
    idle(2);
    scan(40'd0, 0, "cap_after_abort", cap);
    chk("abort_status", cap, 0);

    for (int it = 0; it < 80; it++) begin
      op = ops[$urandom_range(0, 7)];
      d = 30'($urandom);
      scan(mk(op, 6'($urandom_range(0, 47)), d), 1, "cap_random", cap);
      if (op == 4'h4 && $urandom_range(0, 1) == 1) quick_update();
      idle(($urandom_range(0, 4) == 0) ? $urandom_range(5, 45) : $urandom_range(0, 3));
    end
    idle(50);
    scan(40'd0, 0, "cap_final", cap);
    chk("scoreboard_empty", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
